// File: rtl/stos_pkg.sv
// Shared types and default sizes for the LIFO stack controller and the
// stack instance it drives.
package stos_pkg;

    localparam int STOS_DATA_W = 8;
    localparam int STOS_DEPTH  = 32;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } stos_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXEC    = 2'b01,
        RESTORE = 2'b10,
        RESP    = 2'b11
    } stos_state_t;

endpackage

// File: rtl/stos_ctrl_if.sv
// Request/response channel between the ID stage and the stack controller.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_op/req_data are only looked at on that edge.
// The controller does not back-pressure responses: resp_valid is a
// single-cycle pulse, one per accepted request, and resp_data/resp_err are
// meaningful only while resp_valid is high.
interface stos_ctrl_if
    import stos_pkg::*;
#(
    parameter int DATA_W = STOS_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    stos_op_t          req_op;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // ID-stage side
    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // Controller side
    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/stos_ctrl.sv
// Stack controller: accepts PUSH/POP/PEEK/NOP requests, sequences the stack
// push/pop strobes, captures popped data, implements PEEK as pop-then-restore
// and keeps illegal strobes (push when full, pop when empty) away from the
// stack, reporting them as errors instead.
module stos_ctrl
    import stos_pkg::*;
#(
    parameter int DATA_W = STOS_DATA_W,
    parameter int DEPTH  = STOS_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    stos_ctrl_if.slave              req_if,
    output logic                    err_overflow,
    output logic                    err_underflow,
    input  logic                    err_clr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    st_push,
    output logic                    st_pop,
    output logic [DATA_W-1:0]       st_data_in,
    input  logic [DATA_W-1:0]       st_data_out,
    input  logic                    st_full,
    input  logic                    st_empty,
    output stos_state_t             dbg_state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    stos_state_t       state_q;
    stos_op_t          op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_err_q;
    logic              resp_valid_q;
    logic              set_ovf;
    logic              set_udf;

    assign req_if.req_ready  = (state_q == IDLE) && !rst;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;
    assign req_if.resp_err   = resp_err_q;
    assign dbg_state         = state_q;

    // Stack strobes and error detection, decoded from the registered state
    // and latched op; suppressed while rst is high so a reset mid-PEEK
    // never reaches the stack as a stray push.
    always_comb begin
        st_push    = 1'b0;
        st_pop     = 1'b0;
        st_data_in = '0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        if (!rst) begin
            case (state_q)
                EXEC: begin
                    case (op_q)
                        OP_PUSH: begin
                            if (st_full) begin
                                set_ovf = 1'b1;
                            end else begin
                                st_push    = 1'b1;
                                st_data_in = data_q;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (st_empty) set_udf = 1'b1;
                            else          st_pop  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                RESTORE: begin
                    // Put the peeked word (already captured for the response) back
                    st_push    = 1'b1;
                    st_data_in = resp_data_q;
                end
                default: ;
            endcase
        end
    end

    // Request sequencing FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_NOP;
            data_q       <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_if.req_valid) begin
                        op_q    <= req_if.req_op;
                        data_q  <= req_if.req_data;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_q  <= '0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                    case (op_q)
                        OP_PUSH: resp_err_q <= st_full;
                        OP_POP: begin
                            if (st_empty) resp_err_q  <= 1'b1;
                            else          resp_data_q <= st_data_out;
                        end
                        OP_PEEK: begin
                            if (st_empty) begin
                                resp_err_q <= 1'b1;
                            end else begin
                                resp_data_q  <= st_data_out;
                                resp_valid_q <= 1'b0;
                                state_q      <= RESTORE;
                            end
                        end
                        default: ;
                    endcase
                end
                RESTORE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky error flags: a set in the same cycle as err_clr wins
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (err_clr) begin
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
            end
            if (set_ovf) err_overflow  <= 1'b1;
            if (set_udf) err_underflow <= 1'b1;
        end
    end

    // Occupancy mirror tracking every strobe sent to the stack
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(st_push) - CNT_W'(st_pop);
        end
    end

endmodule
